// File: rtl/led_pattern_player.sv
// led_pattern_player: Avalon-style read master that plays timed LED patterns out of a 1024x32 pattern memory.
// Optional build macro LED_PATTERN_PLAYER_PWM_EN gates each LED with an 8-bit PWM driven by the word's DUTY field.

module led_pattern_player #(
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [9:0]       start_addr,
    output logic [9:0]       mem_address,
    output logic             mem_chipselect,
    output logic             mem_clken,
    output logic             mem_write,
    output logic [3:0]       mem_byteenable,
    input  logic [31:0]      mem_readdata,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    state_t             state_r, state_s;
    logic [9:0]         addr_r, addr_s;
    logic [9:0]         start_addr_r, start_addr_s;
    logic [LED_W-1:0]   pattern_r, pattern_s;
    logic [7:0]         duty_r, duty_s;
    logic [13:0]        hold_r, hold_s;
    logic               end_r, end_s;
    logic [PRESC_W-1:0] presc_r, presc_s;
    logic [13:0]        tick_r, tick_s;
    logic [13:0]        tick_inc_s;
    logic [13:0]        hold_field_s;
    logic               done_s;
    logic [LED_W-1:0]   led_s;
    logic [LED_W-1:0]   led_r;
    logic               busy_r;
    logic               done_r;
    logic               cs_r;
    logic               unused_s;

    assign hold_field_s = mem_readdata[29:16];
    assign tick_inc_s   = tick_r + 14'd1;

    // Next-state, word fields and hold timing; stop overrides everything and blanks the pattern.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        start_addr_s = start_addr_r;
        pattern_s    = pattern_r;
        duty_s       = duty_r;
        hold_s       = hold_r;
        end_s        = end_r;
        presc_s      = presc_r;
        tick_s       = tick_r;
        done_s       = 1'b0;
        if (stop) begin
            state_s   = ST_IDLE;
            pattern_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s      = ST_FETCH;
                        addr_s       = start_addr;
                        start_addr_s = start_addr;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_s = ST_LOAD;
                end
                ST_LOAD: begin
                    pattern_s = mem_readdata[LED_W-1:0];
                    duty_s    = mem_readdata[15:8];
                    end_s     = mem_readdata[31];
                    if (hold_field_s == 14'd0) begin
                        hold_s = 14'd1;
                    end else begin
                        hold_s = hold_field_s;
                    end
                    presc_s = '0;
                    tick_s  = 14'd0;
                    state_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (presc_r == PRESC_MAX) begin
                        presc_s = '0;
                        tick_s  = tick_inc_s;
                        if (tick_inc_s == hold_r) begin
                            // Word expired: advance, wrap to the latched start, or finish.
                            if (!end_r) begin
                                addr_s  = addr_r + 10'd1;
                                state_s = ST_FETCH;
                            end else if (loop_en) begin
                                addr_s  = start_addr_r;
                                state_s = ST_FETCH;
                            end else begin
                                state_s   = ST_IDLE;
                                done_s    = 1'b1;
                                pattern_s = '0;
                            end
                        end else begin
                            state_s = ST_HOLD;
                        end
                    end else begin
                        presc_s = presc_r + PRESC_W'(1);
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    pattern_s = '0;
                end
            endcase
        end
    end

`ifdef LED_PATTERN_PLAYER_PWM_EN
    logic [7:0] pwm_r, pwm_s;
    logic       pwm_on_s;

    // The LED register is loaded with the value matching the PWM count it will coincide with.
    always_comb begin
        pwm_s    = pwm_r + 8'd1;
        pwm_on_s = (pwm_s < duty_s);
        led_s    = pattern_s & {LED_W{pwm_on_s}};
    end

    // Free-running PWM counter, active in every state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_r <= 8'd0;
        end else begin
            pwm_r <= pwm_s;
        end
    end
`else
    assign led_s = pattern_s;
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= 10'd0;
            start_addr_r <= 10'd0;
            pattern_r    <= '0;
            duty_r       <= 8'd0;
            hold_r       <= 14'd0;
            end_r        <= 1'b0;
            presc_r      <= '0;
            tick_r       <= 14'd0;
            led_r        <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cs_r         <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            start_addr_r <= start_addr_s;
            pattern_r    <= pattern_s;
            duty_r       <= duty_s;
            hold_r       <= hold_s;
            end_r        <= end_s;
            presc_r      <= presc_s;
            tick_r       <= tick_s;
            led_r        <= led_s;
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= done_s;
            cs_r         <= (state_s == ST_FETCH);
        end
    end

    // addr_r only moves on entry to FETCH, so it already holds its value elsewhere.
    assign mem_address    = addr_r;
    assign mem_chipselect = cs_r;
    assign mem_clken      = cs_r;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign led            = led_r;
    assign busy           = busy_r;
    assign done           = done_r;

    assign unused_s = ^{mem_readdata, duty_r};

endmodule

// File: tb/tb_led_pattern_player.sv
// Testbench for led_pattern_player: directed and randomized playback against a word-level trace model.
// The expected trace is built from the memory image and the display rules, then compared every cycle.

module tb_led_pattern_player;

    localparam int TD = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [9:0]  start_addr;
    logic [9:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [7:0]  led;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:1023];
    int          n_checks;
    int          n_errors;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] duty;
        logic       busy;
        logic       done;
        logic       cs;
        logic [9:0] addr;
    } exp_t;

    exp_t q[$];

    led_pattern_player #(.LED_W(8), .TICK_DIV(TD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .loop_en        (loop_en),
        .start_addr     (start_addr),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .led            (led),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after a selected read.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) mem_readdata <= mem[mem_address];
    end

`ifdef LED_PATTERN_PLAYER_PWM_EN
    logic [7:0] pwm_m;
    always @(posedge clk) begin
        if (!reset_n) pwm_m <= 8'd0;
        else          pwm_m <= pwm_m + 8'd1;
    end
`endif

    function automatic logic [7:0] exp_led(input logic [7:0] pat, input logic [7:0] duty);
`ifdef LED_PATTERN_PLAYER_PWM_EN
        return (pwm_m < duty) ? pat : 8'd0;
`else
        return pat | (duty & 8'd0);
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_led"},  {24'd0, led}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_cs"},   {31'd0, mem_chipselect}, 32'd0);
        check_eq({tag, "_ce"},   {31'd0, mem_clken}, 32'd0);
    endtask

    // Expected per-cycle trace from the cycle after start: 2 fetch/load cycles per word,
    // then HOLD*TD display cycles, then advance, wrap to start, or a done cycle and idle.
    task automatic build_trace(input logic [9:0] sa, input bit lp, input int max_len);
        logic [7:0]  pp;
        logic [7:0]  pd;
        logic [9:0]  a;
        logic [31:0] w;
        int          h;
        exp_t        e;
        q.delete();
        pp = 8'd0;
        pd = 8'd0;
        a  = sa;
        while (q.size() < max_len) begin
            w = mem[a];
            e.pat = pp; e.duty = pd; e.busy = 1'b1; e.done = 1'b0; e.cs = 1'b1; e.addr = a;
            q.push_back(e);
            e.cs = 1'b0;
            q.push_back(e);
            h = (w[29:16] == 14'd0) ? 1 : int'(w[29:16]);
            e.pat = w[7:0];
            e.duty = w[15:8];
            for (int i = 0; i < h * TD && q.size() < max_len; i++) q.push_back(e);
            pp = w[7:0];
            pd = w[15:8];
            if (!w[31]) begin
                a = a + 10'd1;
            end else if (lp) begin
                a = sa;
            end else begin
                e.pat = 8'd0; e.duty = 8'd0; e.busy = 1'b0; e.done = 1'b1; e.cs = 1'b0; e.addr = 10'd0;
                q.push_back(e);
                e.done = 1'b0;
                while (q.size() < max_len) q.push_back(e);
            end
        end
    endtask

    // Called at a negedge with the DUT idle; stop_at < 0 means no mid-play stop.
    task automatic play(input logic [9:0] sa, input bit lp, input int len, input int stop_at, input bit rnd);
        exp_t e;
        build_trace(sa, lp, len);
        start_addr = sa;
        loop_en    = lp;
        start      = 1'b1;
        stop       = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (stop_at >= 0 && k > stop_at) begin
                e.pat = 8'd0; e.duty = 8'd0; e.busy = 1'b0; e.done = 1'b0; e.cs = 1'b0; e.addr = 10'd0;
            end else begin
                e = q[k];
            end
            check_eq("led",  {24'd0, led}, {24'd0, exp_led(e.pat, e.duty)});
            check_eq("busy", {31'd0, busy}, {31'd0, e.busy});
            check_eq("done", {31'd0, done}, {31'd0, e.done});
            check_eq("cs",   {31'd0, mem_chipselect}, {31'd0, e.cs});
            check_eq("ce",   {31'd0, mem_clken}, {31'd0, e.cs});
            if (e.cs) check_eq("addr", {22'd0, mem_address}, {22'd0, e.addr});
            stop  = (k == stop_at);
            start = rnd && e.busy && (k != stop_at) && ($urandom_range(0, 7) == 0);
            if (rnd) start_addr = 10'($urandom);
        end
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        check_idle("after_stop");
        stop = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [9:0]  sa;
        int          len;
        int          sat;
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        loop_en    = 1'b0;
        start_addr = 10'd0;
        mem_readdata = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        repeat (3) @(negedge clk);
        check_idle("reset");
        check_eq("reset_addr", {22'd0, mem_address}, 32'd0);
        check_eq("mem_write", {31'd0, mem_write}, 32'd0);
        check_eq("byteenable", {28'd0, mem_byteenable}, 32'hF);
        reset_n = 1'b1;
        @(negedge clk);

        // Two-word sequence, single shot then looping.
        mem[5] = 32'h0003_FF0A;
        mem[6] = 32'h8001_FF05;
        play(10'd5, 1'b0, 26, -1, 1'b0);
        play(10'd5, 1'b1, 70, -1, 1'b1);

        // Address wrap 1023 -> 0.
        mem[1023] = 32'h0001_0011;
        mem[0]    = 32'h8001_0022;
        play(10'd1023, 1'b0, 16, -1, 1'b1);

        // Stop in the middle of the first HOLD.
        play(10'd5, 1'b0, 26, 8, 1'b0);

        // start and stop together in IDLE: nothing begins.
        start_addr = 10'd5;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        check_idle("start_stop");
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check_idle("start_stop2");

        // Reset asserted during LOAD.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("rst_fetch_cs", {31'd0, mem_chipselect}, 32'd1);
        @(negedge clk);
        check_eq("rst_load_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle("rst_load");
        check_eq("rst_load_addr", {22'd0, mem_address}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("rst_after");

        // HOLD=0 is shown for one tick.
        mem[10] = 32'h8000_FF33;
        play(10'd10, 1'b0, 12, -1, 1'b0);

        // DUTY=0x40 with pattern 0x01 over a long hold.
        mem[20] = 32'h8050_4001;
        play(10'd20, 1'b0, 330, -1, 1'b0);

        // Randomized sequences in a scratch region.
        for (int it = 0; it < 12; it++) begin
            for (int i = 100; i < 132; i++) begin
                w = {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'b0,
                     14'($urandom_range(0, 2)), 8'($urandom), 8'($urandom)};
                mem[i] = w;
            end
            sa  = 10'(100 + $urandom_range(0, 31));
            len = int'($urandom_range(40, 160));
            sat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 39)) : -1;
            play(sa, ($urandom_range(0, 1) == 1), len, sat, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
